// File: rtl/float_copro_arbiter.sv
// Round-robin sequencer sharing one combinational float datapath
// between N_REQ coprocessor requesters (valid/complete/accept).
module float_copro_arbiter #(
  parameter int N_REQ  = 2,
  parameter int T_ADD  = 3,
  parameter int T_SUB  = 3,
  parameter int T_MULT = 2,
  parameter int T_DIV  = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*11-1:0]        req_opcode,
  input  logic [N_REQ*32-1:0]        req_op0,
  input  logic [N_REQ*32-1:0]        req_op1,
  input  logic [N_REQ-1:0]           req_accept,
  output logic [N_REQ-1:0]           req_complete,
  output logic [31:0]                req_result,
  output logic [10:0]                dp_opcode,
  output logic [31:0]                dp_op0,
  output logic [31:0]                dp_op1,
  input  logic [31:0]                dp_result,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]  complete_q, complete_d;
  logic [31:0]       result_q, result_d;
  logic [10:0]       opc_q, opc_d;
  logic [31:0]       op0_q, op0_d;
  logic [31:0]       op1_q, op1_d;
  logic              busy_q, busy_d;
  logic              win_ok;
  logic [IW-1:0]     win_id;

  function automatic logic [15:0] lat(input logic [10:0] opc);
    case (opc)
      11'd0:   lat = 16'(T_ADD);
      11'd1:   lat = 16'(T_SUB);
      11'd2:   lat = 16'(T_MULT);
      default: lat = 16'(T_DIV);
    endcase
  endfunction

  // Scan from farthest to nearest so last+1 wins.
  always_comb begin
    win_ok = 1'b0;
    win_id = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req_valid[(int'(last_q) + i) % N_REQ]) begin
        win_ok = 1'b1;
        win_id = IW'((int'(last_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    grant_d    = grant_q;
    complete_d = complete_q;
    result_d   = result_q;
    opc_d      = opc_q;
    op0_d      = op0_q;
    op1_d      = op1_q;
    unique case (state_q)
      IDLE: begin
        if (win_ok) begin
          opc_d   = req_opcode[int'(win_id)*11 +: 11];
          op0_d   = req_op0[int'(win_id)*32 +: 32];
          op1_d   = req_op1[int'(win_id)*32 +: 32];
          grant_d = win_id;
          cnt_d   = lat(req_opcode[int'(win_id)*11 +: 11]);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 16'd1) begin
          result_d            = dp_result;
          complete_d          = '0;
          complete_d[grant_q] = 1'b1;
          state_d             = DONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DONE: begin
        if (req_accept[grant_q]) begin
          complete_d = '0;
          last_d     = grant_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= IW'(N_REQ - 1);
      grant_q    <= '0;
      complete_q <= '0;
      result_q   <= '0;
      opc_q      <= '0;
      op0_q      <= '0;
      op1_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      complete_q <= complete_d;
      result_q   <= result_d;
      opc_q      <= opc_d;
      op0_q      <= op0_d;
      op1_q      <= op1_d;
      busy_q     <= busy_d;
    end
  end

  assign req_complete = complete_q;
  assign req_result   = result_q;
  assign dp_opcode    = opc_q;
  assign dp_op0       = op0_q;
  assign dp_op1       = op1_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;

endmodule

// File: tb/tb_float_copro_arbiter.sv
// Bench for float_copro_arbiter: transaction-level model with
// per-cycle compare, directed scenarios and a random phase.
module tb_float_copro_arbiter;
  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*11-1:0] req_opcode;
  logic [N*32-1:0] req_op0;
  logic [N*32-1:0] req_op1;
  logic [N-1:0]    req_accept;
  logic [N-1:0]    req_complete;
  logic [31:0]     req_result;
  logic [10:0]     dp_opcode;
  logic [31:0]     dp_op0;
  logic [31:0]     dp_op1;
  logic [31:0]     dp_result;
  logic            busy;
  logic [0:0]      grant_id;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  float_copro_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_opcode(req_opcode),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_accept(req_accept), .req_complete(req_complete),
    .req_result(req_result), .dp_opcode(dp_opcode),
    .dp_op0(dp_op0), .dp_op1(dp_op1), .dp_result(dp_result),
    .busy(busy), .grant_id(grant_id)
  );

  // Datapath stand-in: exact float answers for the named cases,
  // an operand-sensitive mix otherwise.
  function automatic logic [31:0] dp_fn(input logic [10:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    if (o == 0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (o == 2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (o == 1 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (o == 3 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return (a * 32'd3) + (b ^ {21'd0, o});
  endfunction

  assign dp_result = dp_fn(dp_opcode, dp_op0, dp_op1);

  function automatic int lat_of(input logic [10:0] o);
    if (o == 11'd0) return 3;
    if (o == 11'd1) return 3;
    if (o == 11'd2) return 2;
    return 12;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Transaction model: one op in flight, finishing at a cycle stamp.
  int          cyc = 0;
  bit          m_busy, m_done, m_new_grant;
  int          m_grant, m_last, m_fin, ops_done = 0;
  logic [10:0] m_opc;
  logic [31:0] m_a, m_b, m_res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_new_grant = 0;
      m_grant = 0; m_last = N - 1;
      m_opc = 0; m_a = 0; m_b = 0; m_res = 0;
    end else begin
      m_new_grant = 0;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (req_valid[c] && !m_new_grant) begin
            m_grant = c;
            m_opc = req_opcode[c*11 +: 11];
            m_a = req_op0[c*32 +: 32];
            m_b = req_op1[c*32 +: 32];
            m_fin = cyc + lat_of(m_opc);
            m_busy = 1;
            m_new_grant = 1;
          end
        end
      end else if (!m_done) begin
        if (cyc == m_fin) begin
          m_done = 1;
          m_res = dp_fn(m_opc, m_a, m_b);
        end
      end else if (req_accept[m_grant]) begin
        m_busy = 0; m_done = 0;
        m_last = m_grant;
        ops_done++;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      chk("complete", req_complete, m_done ? (64'd1 << m_grant) : 64'd0);
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_grant);
      chk("dp_opcode", dp_opcode, m_opc);
      chk("dp_op0", dp_op0, m_a);
      chk("dp_op1", dp_op1, m_b);
      if (m_done) chk("result", req_result, m_res);
    end
  end

  task automatic do_reset();
    reset_n = 0;
    req_valid = 0;
    req_accept = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic [10:0] o,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[id] = 1'b1;
    req_opcode[id*11 +: 11] = o;
    req_op0[id*32 +: 32] = a;
    req_op1[id*32 +: 32] = b;
  endtask

  // Call at a negedge with requests posted; the next edge is the grant.
  task automatic serve(input int id, input int lat,
                       input logic [31:0] res, input bit drop);
    int n;
    @(negedge clk);
    chk("grant", grant_id, id);
    chk("busy_on", busy, 1);
    if (drop) begin
      req_valid[id] = 1'b0;
      req_opcode[id*11 +: 11] = 11'($urandom);
      req_op0[id*32 +: 32] = $urandom;
      req_op1[id*32 +: 32] = $urandom;
    end
    n = 0;
    while (req_complete == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    chk("onehot", req_complete, 64'd1 << id);
    chk("op_result", req_result, res);
    req_accept[(id + 1) % N] = 1'b1;
    @(negedge clk);
    req_accept = '0;
    chk("hold", req_complete, 64'd1 << id);
    req_accept[id] = 1'b1;
    @(negedge clk);
    req_accept = '0;
    chk("release", {busy, req_complete}, 0);
  endtask

  initial begin
    bit wt[N];
    bit inf[N];
    int ops0;
    logic [31:0] x, y;
    reset_n = 0;
    req_valid = 0; req_opcode = 0; req_op0 = 0; req_op1 = 0;
    req_accept = 0;
    do_reset();
    chk_en = 1;
    chk("rst_complete", req_complete, 0);
    chk("rst_result", req_result, 0);
    chk("rst_dp_opcode", dp_opcode, 0);
    chk("rst_dp_op0", dp_op0, 0);
    chk("rst_dp_op1", dp_op1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);

    set_req(0, 11'd0, 32'h3F800000, 32'h40000000);
    serve(0, 3, 32'h40400000, 1);

    do_reset();
    set_req(0, 11'd2, 32'h40000000, 32'h40400000);
    set_req(1, 11'd1, 32'h40400000, 32'h3F800000);
    serve(0, 2, 32'h40C00000, 1);
    serve(1, 3, 32'h40000000, 1);

    x = $urandom; y = $urandom;
    set_req(0, 11'd0, x, y);
    set_req(1, 11'd2, y, x);
    serve(0, 3, dp_fn(11'd0, x, y), 0);
    serve(1, 2, dp_fn(11'd2, y, x), 0);
    serve(0, 3, dp_fn(11'd0, x, y), 0);
    serve(1, 2, dp_fn(11'd2, y, x), 0);
    req_valid = 0;

    set_req(0, 11'd3, 32'h40C00000, 32'h40000000);
    serve(0, 12, 32'h40400000, 1);
    set_req(1, 11'd7, x, y);
    serve(1, 12, dp_fn(11'd7, x, y), 1);

    set_req(0, 11'd2, y, y);
    serve(0, 2, dp_fn(11'd2, y, y), 1);
    set_req(1, 11'd3, 32'h40C00000, 32'h40000000);
    @(negedge clk);
    req_valid = 0;
    repeat (5) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("arst_complete", req_complete, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant_id, 0);
    chk("arst_dp_opcode", dp_opcode, 0);
    chk("arst_dp_op0", dp_op0, 0);
    chk("arst_result", req_result, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (20) @(negedge clk);
    chk("no_complete", req_complete, 0);
    set_req(0, 11'd1, 32'h40400000, 32'h3F800000);
    set_req(1, 11'd0, 32'h3F800000, 32'h40000000);
    serve(0, 3, 32'h40000000, 1);
    serve(1, 3, 32'h40400000, 1);

    ops0 = ops_done;
    for (int i = 0; i < N; i++) begin
      wt[i] = 0;
      inf[i] = 0;
    end
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (wt[i] && m_new_grant && m_grant == i) begin
          wt[i] = 0;
          inf[i] = 1;
          if ($urandom % 2 == 0) req_valid[i] = 1'b0;
          req_opcode[i*11 +: 11] = 11'($urandom % 8);
          req_op0[i*32 +: 32] = $urandom;
          req_op1[i*32 +: 32] = $urandom;
        end else if (inf[i] && !m_busy) begin
          inf[i] = 0;
          wt[i] = req_valid[i];
        end else if (!wt[i] && !inf[i]) begin
          if ($urandom % 4 == 0) begin
            x = $urandom;
            set_req(i, ($urandom % 8 == 7) ? 11'($urandom)
                                           : 11'($urandom % 4),
                    x, $urandom);
            wt[i] = 1;
          end
        end else if (wt[i] && $urandom % 16 == 0) begin
          req_valid[i] = 1'b0;
          wt[i] = 0;
        end
      end
      req_accept = N'($urandom);
    end
    req_accept = '0;
    req_valid = '0;
    chk("random_progress", (ops_done - ops0) >= 30, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
